// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered execute stage with forwarding muxes, ALU, iterative shift-add
// multiplier (stalls the front end) and the EX/MEM register. Define EX_OVF_EN for out_ovf.
module ex_stage_pipe #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            flush,
    input  logic            mem_stall,
    input  logic [3:0]      alu_op,
    input  logic            alu_src,
    input  logic            reg_dst,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            branch,
    input  logic            jump,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] j_target,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic [XLEN-1:0] wb_fwd,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    output logic            stall_req,
    output logic            out_valid,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_branch_target,
    output logic [XLEN-1:0] out_j_target,
    output logic            out_zero,
    output logic [REGW-1:0] out_dst_reg,
`ifdef EX_OVF_EN
    output logic            out_ovf,
`endif
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_mem_to_reg,
    output logic            out_branch,
    output logic            out_jump
);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1101,
                           OP_XOR = 4'b1000, OP_NOR = 4'b1001, OP_SLL = 4'b1010,
                           OP_SRL = 4'b1011, OP_SRA = 4'b1100, OP_LUI = 4'b1111,
                           OP_MUL = 4'b1110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] branch_target;
        logic [XLEN-1:0] j_target;
        logic            zero;
        logic [REGW-1:0] dst_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jump;
`ifdef EX_OVF_EN
        logic            ovf;
`endif
    } exmem_t;

    state_t          state_reg, state_next;
    logic [SHW:0]    cnt_reg, cnt_next;
    logic [XLEN-1:0] mcand_reg, mcand_next, mplier_reg, mplier_next, acc_reg, acc_next;
    exmem_t          exmem_reg, exmem_next, lat_reg, cand;
    logic            mul_start;

    logic [XLEN-1:0] op_a, fwd_b_val, op_b, alu_res, sum, diff, lui_val;
    logic [XLEN-1:0] and_v, or_v, xor_v, nor_v;
    logic [SHW-1:0]  shamt;
    logic            slt_s, slt_u;

    always_comb begin
        case (fwd_a)
            2'd1:    op_a = wb_fwd;
            2'd2:    op_a = mem_fwd;
            default: op_a = rs_data;
        endcase
        case (fwd_b)
            2'd1:    fwd_b_val = wb_fwd;
            2'd2:    fwd_b_val = mem_fwd;
            default: fwd_b_val = rt_data;
        endcase
    end

    assign op_b    = alu_src ? imm : fwd_b_val;
    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign slt_s   = $signed(op_a) < $signed(op_b);
    assign slt_u   = op_a < op_b;
    assign shamt   = imm[SHW+5:6];
    assign lui_val = XLEN'({imm[15:0], 16'h0000});

    for (genvar gi = 0; gi < XLEN; gi++) begin : g_logic
        assign and_v[gi] = op_a[gi] & op_b[gi];
        assign or_v[gi]  = op_a[gi] | op_b[gi];
        assign xor_v[gi] = op_a[gi] ^ op_b[gi];
        assign nor_v[gi] = ~(op_a[gi] | op_b[gi]);
    end

    // Shifts operate on the forwarded rt value; the shamt lives in the immediate.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_AND:  alu_res = and_v;
            OP_OR:   alu_res = or_v;
            OP_XOR:  alu_res = xor_v;
            OP_NOR:  alu_res = nor_v;
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, slt_u};
            OP_SLL:  alu_res = fwd_b_val << shamt;
            OP_SRL:  alu_res = fwd_b_val >> shamt;
            OP_SRA:  alu_res = $signed(fwd_b_val) >>> shamt;
            OP_LUI:  alu_res = lui_val;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_OVF_EN
    logic ovf;
    always_comb begin
        ovf = 1'b0;
        if (alu_op == OP_ADD)
            ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
        else if (alu_op == OP_SUB)
            ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
    end
`endif

    always_comb begin
        cand               = '0;
        cand.valid         = 1'b1;
        cand.alu_result    = alu_res;
        cand.store_data    = fwd_b_val;
        cand.branch_target = pc_plus4 + (imm << 2);
        cand.j_target      = j_target;
        cand.zero          = (op_a == op_b);
        cand.dst_reg       = reg_dst ? rd : rt;
        cand.mem_read      = mem_read;
        cand.mem_write     = mem_write;
        cand.mem_to_reg    = mem_to_reg;
        cand.branch        = branch;
        cand.jump          = jump;
`ifdef EX_OVF_EN
        cand.ovf           = ovf;
        cand.reg_write     = reg_write & ~ovf;
`else
        cand.reg_write     = reg_write;
`endif
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        stall_req   = 1'b0;
        mul_start   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid && alu_op == OP_MUL && !flush) begin
                    stall_req   = 1'b1;
                    mul_start   = 1'b1;
                    mcand_next  = op_a;
                    mplier_next = op_b;
                    acc_next    = '0;
                    cnt_next    = (SHW+1)'(XLEN);
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                stall_req   = 1'b1;
                if (mplier_reg[0])
                    acc_next = acc_reg + mcand_reg;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg - (SHW+1)'(1);
                if (cnt_reg == (SHW+1)'(1))
                    state_next = DONE;
            end
            DONE: begin
                // The product must reach EX/MEM before the front end may advance.
                if (mem_stall)
                    stall_req = 1'b1;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_comb begin
        exmem_next = exmem_reg;
        if (!mem_stall) begin
            exmem_next = '0;
            if (!flush) begin
                if (state_reg == DONE) begin
                    exmem_next            = lat_reg;
                    exmem_next.valid      = 1'b1;
                    exmem_next.alu_result = acc_reg;
                end else if (state_reg == IDLE && in_valid && !mul_start) begin
                    exmem_next = cand;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            exmem_reg  <= '0;
            lat_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            exmem_reg  <= exmem_next;
            if (mul_start)
                lat_reg <= cand;
        end
    end

    assign out_valid         = exmem_reg.valid;
    assign out_alu_result    = exmem_reg.alu_result;
    assign out_store_data    = exmem_reg.store_data;
    assign out_branch_target = exmem_reg.branch_target;
    assign out_j_target      = exmem_reg.j_target;
    assign out_zero          = exmem_reg.zero;
    assign out_dst_reg       = exmem_reg.dst_reg;
    assign out_reg_write     = exmem_reg.reg_write;
    assign out_mem_read      = exmem_reg.mem_read;
    assign out_mem_write     = exmem_reg.mem_write;
    assign out_mem_to_reg    = exmem_reg.mem_to_reg;
    assign out_branch        = exmem_reg.branch;
    assign out_jump          = exmem_reg.jump;
`ifdef EX_OVF_EN
    assign out_ovf           = exmem_reg.ovf;
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed vectors for ex_stage_pipe; expected EX/MEM entries are queued
// at issue and popped by a monitor on each newly loaded valid entry. Honours EX_OVF_EN.
`timescale 1ns/1ps
module tb_ex_stage_pipe;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1101,
                           OP_XOR = 4'b1000, OP_NOR = 4'b1001, OP_SLL = 4'b1010,
                           OP_SRL = 4'b1011, OP_SRA = 4'b1100, OP_LUI = 4'b1111,
                           OP_MUL = 4'b1110;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, mem_stall;
    logic [3:0]  alu_op;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch, jump;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] rs_data, rt_data, imm, pc_plus4, j_target, mem_fwd, wb_fwd;
    logic [4:0]  rt, rd;
    logic        stall_req, out_valid, out_zero;
    logic [31:0] out_alu_result, out_store_data, out_branch_target, out_j_target;
    logic [4:0]  out_dst_reg;
    logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_jump;
`ifdef EX_OVF_EN
    logic        out_ovf;
`endif

    ex_stage_pipe #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush), .mem_stall(mem_stall),
        .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .branch(branch), .jump(jump), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .pc_plus4(pc_plus4),
        .j_target(j_target), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .rt(rt), .rd(rd),
        .stall_req(stall_req), .out_valid(out_valid), .out_alu_result(out_alu_result),
        .out_store_data(out_store_data), .out_branch_target(out_branch_target),
        .out_j_target(out_j_target), .out_zero(out_zero), .out_dst_reg(out_dst_reg),
`ifdef EX_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_branch(out_branch), .out_jump(out_jump)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] store;
        logic [31:0] btgt;
        logic [31:0] jt;
        logic        zero;
        logic [4:0]  dst;
        logic        rw;
        logic        br;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic        src;
        logic [31:0] res;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    logic mem_stall_q = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // A new EX/MEM entry exists only if the register was allowed to load on the last edge.
    always @(posedge clk) mem_stall_q <= mem_stall | reset;

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && !mem_stall_q) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got result 0x%08h, required no entry", out_alu_result);
            end else begin
                e = sb_q.pop_front();
                $display("entry: result=0x%08h expected=0x%08h dst=%0d", out_alu_result, e.res, out_dst_reg);
                chk("result", out_alu_result, e.res);
                chk("store_data", out_store_data, e.store);
                chk("branch_target", out_branch_target, e.btgt);
                chk("j_target", out_j_target, e.jt);
                chk("zero", 32'(out_zero), 32'(e.zero));
                chk("dst_reg", 32'(out_dst_reg), 32'(e.dst));
                chk("reg_write", 32'(out_reg_write), 32'(e.rw));
                chk("branch", 32'(out_branch), 32'(e.br));
`ifdef EX_OVF_EN
                chk("ovf", 32'(out_ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 0; flush = 0; mem_stall = 0; alu_op = 0; alu_src = 0; reg_dst = 0;
        reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; branch = 0; jump = 0;
        fwd_a = 0; fwd_b = 0; rs_data = 0; rt_data = 0; imm = 0; pc_plus4 = 0;
        j_target = 0; mem_fwd = 0; wb_fwd = 0; rt = 0; rd = 0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic src, input logic br,
                          input logic [31:0] pc);
        idle_in();
        in_valid = 1; alu_op = op; rs_data = a; rt_data = b; imm = im; alu_src = src;
        branch = br; pc_plus4 = pc; reg_write = 1; reg_dst = 1; rd = 5'd9; rt = 5'd4;
        j_target = 32'h4000_0000;
    endtask

    function automatic exp_t mk_exp(input logic [31:0] res, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] im,
                                    input logic src, input logic br, input logic [31:0] pc,
                                    input logic rw, input logic ovf);
        exp_t e;
        e.res   = res;
        e.store = b;
        e.btgt  = pc + (im << 2);
        e.jt    = 32'h4000_0000;
        e.zero  = (a == (src ? im : b));
        e.dst   = 5'd9;
        e.rw    = rw;
        e.br    = br;
        e.ovf   = ovf;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [31:0] res);
        set_op(op, a, b, im, src, 1'b0, 32'h0);
        sb_q.push_back(mk_exp(res, a, b, im, src, 1'b0, 32'h0, 1'b1, 1'b0));
        step();
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                           input int holds);
        idle_in();
        step();
        set_op(OP_MUL, a, b, 32'h0, 1'b0, 1'b0, 32'h0);
        sb_q.push_back(mk_exp(res, a, b, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
        #1;
        for (int i = 0; i < 33; i++) begin
            chk("mul_stall_req", 32'(stall_req), 32'd1);
            chk("mul_out_valid", 32'(out_valid), 32'd0);
            step();
        end
        for (int h = 0; h < holds; h++) begin
            mem_stall = 1;
            #1;
            chk("done_hold_stall_req", 32'(stall_req), 32'd1);
            chk("done_hold_out_valid", 32'(out_valid), 32'd0);
            step();
        end
        mem_stall = 0;
        #1;
        chk("done_stall_req", 32'(stall_req), 32'd0);
        step();
        idle_in();
        #1;
        chk("after_mul_stall_req", 32'(stall_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in();
        reset = 1;
        repeat (2) step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_stall_req", 32'(stall_req), 32'd0);
        chk("reset_alu_result", out_alu_result, 32'd0);
        chk("reset_dst_reg", 32'(out_dst_reg), 32'd0);
        chk("reset_reg_write", 32'(out_reg_write), 32'd0);
        reset = 0;
        step();

        // Forwarding: A from MEM, B from WB, rt selected as destination.
        idle_in();
        in_valid = 1; alu_op = OP_ADD; fwd_a = 2; mem_fwd = 32'h10; fwd_b = 1; wb_fwd = 32'h5;
        rs_data = 32'hDEAD; rt_data = 32'hBEEF; reg_write = 1; reg_dst = 0; rt = 5'd7; rd = 5'd3;
        sb_q.push_back('{res: 32'h15, store: 32'h5, btgt: 32'h0, jt: 32'h0, zero: 1'b0,
                         dst: 5'd7, rw: 1'b1, br: 1'b0, ovf: 1'b0});
        step();
        chk("fwd_out_valid", 32'(out_valid), 32'd1);
        idle_in();
        in_valid = 1; alu_op = OP_SUB; fwd_a = 1; wb_fwd = 32'h100; fwd_b = 3; rt_data = 32'h20;
        mem_fwd = 32'h999; reg_dst = 1; rd = 5'd9;
        sb_q.push_back('{res: 32'hE0, store: 32'h20, btgt: 32'h0, jt: 32'h0, zero: 1'b0,
                         dst: 5'd9, rw: 1'b0, br: 1'b0, ovf: 1'b0});
        step();

        vecs.push_back('{OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h0,   1'b0, 32'h1});
        vecs.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,   1'b0, 32'h0});
        vecs.push_back('{OP_SLT,  32'h1,        32'hFFFFFFFF, 32'h0,   1'b0, 32'h0});
        vecs.push_back('{OP_SRA,  32'h0,        32'h80000000, 32'h100, 1'b0, 32'hF8000000});
        vecs.push_back('{OP_LUI,  32'h0,        32'h0,        32'h1234, 1'b1, 32'h12340000});
        vecs.push_back('{OP_SUB,  32'h10,       32'h3,        32'h0,   1'b0, 32'hD});
        vecs.push_back('{OP_AND,  32'hF0F0,     32'hFF00,     32'h0,   1'b0, 32'hF000});
        vecs.push_back('{OP_OR,   32'hF0F0,     32'h0F0F,     32'h0,   1'b0, 32'hFFFF});
        vecs.push_back('{OP_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'h0,   1'b0, 32'hF0F0F0F0});
        vecs.push_back('{OP_NOR,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h0,   1'b0, 32'h0000000F});
        vecs.push_back('{OP_SLL,  32'h0,        32'h1,        32'h7C0, 1'b0, 32'h80000000});
        vecs.push_back('{OP_SRL,  32'h0,        32'h80000000, 32'h7C0, 1'b0, 32'h1});
        vecs.push_back('{OP_ADD,  32'h5,        32'h77,       32'hFFFFFFFF, 1'b1, 32'h4});
        vecs.push_back('{4'b0011, 32'h1,        32'h1,        32'h0,   1'b0, 32'h0});
        foreach (vecs[i])
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].src, vecs[i].res);

        // Branch target with a negative immediate and equal operands.
        set_op(OP_SUB, 32'h7, 32'h7, 32'hFFFFFFFE, 1'b0, 1'b1, 32'h100);
        sb_q.push_back(mk_exp(32'h0, 32'h7, 32'h7, 32'hFFFFFFFE, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0));
        step();

        // Signed overflow: reg_write is suppressed only when the overflow flag exists.
        set_op(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0);
`ifdef EX_OVF_EN
        sb_q.push_back(mk_exp(32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1));
`else
        sb_q.push_back(mk_exp(32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
`endif
        step();
        set_op(OP_SUB, 32'h80000000, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0);
`ifdef EX_OVF_EN
        sb_q.push_back(mk_exp(32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1));
`else
        sb_q.push_back(mk_exp(32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
`endif
        step();

        // mem_stall holds a valid single-cycle entry.
        issue(OP_ADD, 32'h2, 32'h3, 32'h0, 1'b0, 32'h5);
        set_op(OP_SUB, 32'h9, 32'h2, 32'h0, 1'b0, 1'b0, 32'h0);
        mem_stall = 1;
        sb_q.push_back(mk_exp(32'h7, 32'h9, 32'h2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
        for (int h = 0; h < 2; h++) begin
            step();
            chk("hold_result", out_alu_result, 32'h5);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        mem_stall = 0;
        step();
        chk("release_result", out_alu_result, 32'h7);

        run_mul(32'h7, 32'h6, 32'd42, 0);
        run_mul(32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 0);
        run_mul(32'h9, 32'h9, 32'd81, 3);

        // Flush on the 10th MUL cycle: no product may ever appear.
        idle_in();
        step();
        set_op(OP_MUL, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        repeat (9) step();
        flush = 1;
        #1;
        chk("flush_cycle_stall_req", 32'(stall_req), 32'd1);
        step();
        idle_in();
        #1;
        chk("post_flush_stall_req", 32'(stall_req), 32'd0);
        chk("post_flush_out_valid", 32'(out_valid), 32'd0);
        repeat (40) step();

        // Reset in the middle of a MUL aborts it.
        set_op(OP_MUL, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        repeat (5) step();
        reset = 1;
        in_valid = 0;
        step();
        chk("rst_mul_stall_req", 32'(stall_req), 32'd0);
        chk("rst_mul_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mul_result", out_alu_result, 32'd0);
        chk("rst_mul_store", out_store_data, 32'd0);
        chk("rst_mul_dst", 32'(out_dst_reg), 32'd0);
        reset = 0;
        idle_in();
        repeat (40) step();
        chk("post_reset_stall_req", 32'(stall_req), 32'd0);
        issue(OP_ADD, 32'h1, 32'h2, 32'h0, 1'b0, 32'h3);
        idle_in();
        repeat (3) step();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised, registered execute stage for the 5-stage pipeline. It is the successor of the combinational EX stage.
- Adds a wider ALU op set, a multi-cycle iterative multiplier with a stall request to the hazard unit, and flush/hold handling.
- Contains the EX/MEM pipeline register.
- Sits between the ID/EX register and the MEM stage. Forwarding selects come from the forwarding unit.

Parameters:
XLEN, 32, datapath width in bits (≥16, power of 2)
REGW, 5, register-index width
SHW, $clog2(XLEN), shift-amount width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  ID/EX holds a real instruction
flush  in  1  kill the instruction currently in EX
mem_stall  in  1  MEM cannot accept; hold the EX/MEM register
alu_op  in  4  decoded ALU control
alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch, jump  in  1 each  control from ID/EX
fwd_a, fwd_b  in  2 each  forwarding selects: 0=regfile, 1=WB, 2=MEM, 3=regfile
rs_data, rt_data, imm, pc_plus4, j_target  in  XLEN each  ID/EX operands
mem_fwd, wb_fwd  in  XLEN each  forwarded values
rt, rd  in  REGW each  destination candidates
stall_req  out  1  freeze IF/ID/EX (combinational)
out_valid  out  1  EX/MEM entry valid
out_alu_result, out_store_data, out_branch_target, out_j_target  out  XLEN each  registered results
out_zero  out  1  registered operand equality
out_dst_reg  out  REGW  registered destination
out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_jump  out  1 each  registered control

Behaviour:
- Reset: state IDLE; every registered output 0; multiplier counter and accumulator 0. A reset during MUL aborts it.
- Operand A is the fwd_a mux output. Forwarded B is the fwd_b mux output. Operand B is imm when alu_src=1, otherwise forwarded B.
- out_store_data = forwarded B. out_zero = (A == operand B).
- out_branch_target = pc_plus4 + (imm << 2), modulo 2^XLEN.
- out_dst_reg = reg_dst ? rd : rt.
- ALU ops:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB
  - 0111 SLT (signed); 1101 SLTU
  - 1000 XOR; 1001 NOR
  - 1010 SLL, 1011 SRL, 1100 SRA: B shifted by imm[SHW+5:6]
  - 1111 LUI = imm[15:0] << 16
  - 1110 MUL: low XLEN bits of the product
  - any other op: result 0
- Single-cycle ops have 1-cycle latency: the EX/MEM register loads on the edge after the inputs are presented, provided mem_stall=0.
- FSM states:
  - IDLE: when in_valid & alu_op==MUL & !flush, stall_req=1 (combinational), A and operand B are latched, counter=XLEN, next state BUSY, and the EX/MEM register loads a bubble (out_valid=0).
  - BUSY: stall_req=1. One shift-add step per cycle; counter decrements. When counter reaches 0, next state DONE. The EX/MEM register loads bubbles.
  - DONE: stall_req=0. The EX/MEM register loads the product with the latched control, then the FSM returns to IDLE.
- MUL occupancy: stall_req is high for XLEN+1 consecutive cycles.
- mem_stall=1: the EX/MEM register holds its value. In DONE, the FSM stays in DONE and stall_req=1 until the load happens. In BUSY, iteration continues.
- flush=1: the instruction in EX is killed, and an in-progress MUL is aborted to IDLE. The EX/MEM register loads a bubble unless mem_stall=1, in which case it holds. stall_req drops the next cycle.
- in_valid=0: the EX/MEM register loads a bubble with all control outputs 0.

Optional Feature:
EX_OVF_EN:
- Defined: adds output out_ovf (1 bit, registered, reset 0). It is set on signed overflow of ADD/SUB; when it is set, out_reg_write is forced to 0.
- Undefined: the port is absent and reg_write passes through unchanged.

Test Plan:
1. fwd_a=2, mem_fwd=0x10; fwd_b=1, wb_fwd=0x5; ADD, alu_src=0 -> next edge: out_alu_result=0x15, out_store_data=0x5, out_valid=1.
2. A=0xFFFFFFFF, B=1: SLT -> 1, SLTU -> 0. SRA of B=0x80000000 with shamt 4 -> 0xF8000000. LUI imm=0x1234 -> 0x12340000.
3. MUL 7×6 -> stall_req high for 33 cycles with out_valid=0 throughout, then out_alu_result=42. 0xFFFFFFFF×2 -> 0xFFFFFFFE.
4. flush at the 10th MUL cycle -> next cycle stall_req=0, state IDLE, out_valid=0, no product emitted. reset mid-MUL -> all outputs 0.
5. mem_stall high for 3 cycles while in DONE -> outputs held, stall_req=1. The product loads on the first edge with mem_stall=0.
6. pc_plus4=0x100, imm=0xFFFFFFFE, branch with equal operands -> out_branch_target=0xF8, out_zero=1. With EX_OVF_EN defined: 0x7FFFFFFF+1 -> out_ovf=1, out_reg_write=0.
